// File: rtl/mul12u_rr_sched.sv
// Round-robin scheduler that shares one external combinational 12x12 unsigned multiplier
// among NREQ requesters, with operand registers feeding the multiplier and a result register.
module mul12u_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_a,
    input  logic [12*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [11:0]          mul_a,
    output logic [11:0]          mul_b,
    input  logic [23:0]          mul_o,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [23:0]          rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
);

    logic [IDW-1:0]  ptr;
    logic [11:0]     op_a;
    logic [11:0]     op_b;
    logic            s1_v;
    logic [IDW-1:0]  s1_id;

    logic            s1_adv;
    logic            can_issue;
    logic            any_grant;
    logic            xfer;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  ptr_next;
    logic [11:0]     sel_a;
    logic [11:0]     sel_b;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!any_grant && req_valid[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_a = req_a[12*k +: 12];
                sel_b = req_b[12*k +: 12];
            end
        end
    end

    assign grant_oh  = any_grant ? (NREQ'(1) << grant_idx) : '0;
    assign s1_adv    = s1_v & (~rsp_valid | rsp_ready);
    assign can_issue = ~s1_v | s1_adv;
    assign req_ready = (rst_n && can_issue) ? grant_oh : '0;
    assign xfer      = rst_n & any_grant & can_issue;
    assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // Operands only move on a transfer so the shared multiplier inputs stay quiet otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            s1_v      <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (xfer) begin
                ptr   <= ptr_next;
                op_a  <= sel_a;
                op_b  <= sel_b;
                s1_id <= grant_idx;
                s1_v  <= 1'b1;
            end else if (s1_adv) begin
                s1_v  <= 1'b0;
            end

            if (s1_adv) begin
                rsp_data  <= mul_o;
                rsp_id    <= s1_id;
                rsp_valid <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign mul_a = op_a;
    assign mul_b = op_b;
    assign busy  = s1_v | rsp_valid;

endmodule

// File: tb/tb_mul12u_rr_sched.sv
// Scoreboard bench for mul12u_rr_sched: a cycle model predicts handshakes and queues expected
// results; a monitor pops and compares on every consumed response.
module tb_mul12u_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic [3:0]  req_ready;
    logic [11:0] mul_a;
    logic [11:0] mul_b;
    logic [23:0] mul_o;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_data;
    logic        rsp_ready;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  id;
        logic [23:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign mul_o = 24'(mul_a) * 24'(mul_b);

    mul12u_rr_sched #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int p);
        logic [1:0] c;
        for (int k = 0; k < 4; k++) begin
            c = 2'((p + k) % 4);
            if (v[c]) return int'(c);
        end
        return -1;
    endfunction

    function automatic logic [11:0] opnd(input logic [47:0] bus, input int i);
        logic [47:0] s;
        s = bus >> (12 * i);
        return s[11:0];
    endfunction

    // Reference model state
    int m_ptr = 0;
    bit m_s1v = 1'b0;
    bit m_rv  = 1'b0;
    int mg;
    bit madv;
    bit mcan;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ptr = 0;
            m_s1v = 1'b0;
            m_rv  = 1'b0;
            exp_q.delete();
        end else begin
            mg   = model_grant(req_valid, m_ptr);
            madv = m_s1v && (!m_rv || rsp_ready);
            mcan = !m_s1v || madv;
            if (madv) m_rv = 1'b1;
            else if (m_rv && rsp_ready) m_rv = 1'b0;
            if (mg >= 0 && mcan) begin
                exp_q.push_back('{id: 2'(mg),
                                  data: 24'(opnd(req_a, mg)) * 24'(opnd(req_b, mg))});
                m_ptr = (mg + 1) % 4;
                m_s1v = 1'b1;
            end else if (madv) begin
                m_s1v = 1'b0;
            end
        end
    end

    // Per-cycle handshake/status check against the model
    int cg;
    bit cadv;
    bit ccan;
    logic [3:0] c_rdy;

    always @(negedge clk) begin
        cg    = model_grant(req_valid, m_ptr);
        cadv  = m_s1v && (!m_rv || rsp_ready);
        ccan  = !m_s1v || cadv;
        c_rdy = (rst_n && ccan && cg >= 0) ? (4'b0001 << cg) : 4'b0000;
        check("cyc_req_ready", 32'(req_ready), 32'(c_rdy));
        check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("cyc_busy", 32'(busy), 32'(m_s1v | m_rv));
    end

    // Scoreboard monitor: one pop per consumed response
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1 && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_rsp: got id %0d data 0x%0h with no expected result at %0t",
                         rsp_id, rsp_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                check("sb_rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] bp_rdy [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
    int         sp_ptr [4] = '{2, 0, 2, 0};
    logic [3:0] sp_rdy [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [3:0] hs;

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        // idx:        3        2        1        0
        req_a     = {12'h0F0, 12'h800, 12'h123, 12'hFFF};
        req_b     = {12'h00F, 12'h800, 12'h456, 12'hFFF};
        rsp_ready = 1'b1;

        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_ptr", 32'(dut.ptr), 32'd0);
        tick();
        rst_n = 1'b1;

        // Sparse requesters 1 and 3 from ptr 0
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sparse_ready", 32'(req_ready), 32'(sp_rdy[k]));
            tick();
            if (k == 3) req_valid = 4'b0000;
            check("sparse_ptr", 32'(dut.ptr), 32'(sp_ptr[k]));
        end
        repeat (3) tick();

        // Fairness: all four valid, 8 grants
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            if (k == 7) req_valid = 4'b0000;
        end
        repeat (3) tick();

        // Single request from requester 2: 0x800 * 0x800
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        check("single_lat1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_ready_gone", 32'(req_ready), 32'h0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd2);
        check("single_data", 32'(rsp_data), 32'h400000);
        repeat (3) tick();

        // Backpressure: three queued, consumer stalled 4 cycles (ptr is 3 here)
        req_valid = 4'b0111;
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'(bp_rdy[c]));
            if (c >= 2) begin
                check("bp_hold_id", 32'(rsp_id), 32'd0);
                check("bp_hold_data", 32'(rsp_data), 32'hFFE001);
            end
            hs = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~hs;
            if (c == 3) rsp_ready = 1'b1;
        end
        repeat (5) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset while both stages are full (ptr is 3 here)
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~hs;
        end
        check("mid_s1_full", 32'(busy & rsp_valid & dut.s1_v), 32'd1);
        rst_n     = 1'b0;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_ready_forced", 32'(req_ready), 32'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_mul_a", 32'(mul_a), 32'd0);
        check("mid_mul_b", 32'(mul_b), 32'd0);
        check("mid_ptr", 32'(dut.ptr), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("mid_no_stale", 32'(rsp_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
